// File: rtl/gpu_fifo_pkg.sv
// Shared definitions for the GPU parametrised FIFOs.
package gpu_fifo_pkg;

  localparam int unsigned CMD_WIDTH = 38;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
module fifo_regfile #(
  parameter int unsigned WIDTH = 38,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             w_en,
  input  logic [AW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic [AW-1:0]    r_addr,
  output logic [WIDTH-1:0] r_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_en) mem_q[w_addr] <= w_data;
  end

  assign r_data = mem_q[r_addr];

endmodule

// File: rtl/gpu_param_fifo.sv
// Circular-buffer FIFO with occupancy count, threshold flags, flush, sticky errors
// and a selectable registered or first-word-fall-through read port.
module gpu_param_fifo
  import gpu_fifo_pkg::*;
#(
  parameter int unsigned WIDTH         = CMD_WIDTH,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned AFULL_THRESH  = DEPTH - 1,
  parameter int unsigned AEMPTY_THRESH = 1,
  parameter bit          FWFT          = 1'b0
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      clear,
  input  logic                      w_enable,
  input  logic [WIDTH-1:0]          w_data,
  input  logic                      r_enable,
  output logic [WIDTH-1:0]          r_data,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
  localparam logic [CW-1:0] AFullC  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEmptyC = CW'(AEMPTY_THRESH);
  localparam bit AFullRst = (AFULL_THRESH == 0);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("gpu_param_fifo: DEPTH must be a power of two >= 2");
  end
  if (!((AEMPTY_THRESH < AFULL_THRESH) && (AFULL_THRESH <= DEPTH))) begin : g_thresh_chk
    $error("gpu_param_fifo: need AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
  end

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, full_q, aempty_q, afull_q, ovf_q, unf_q;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] rd_word;

  // Acceptance uses the registered flags only, so no same-cycle pass-through.
  assign wr_acc = w_enable && !full_q  && !clear;
  assign rd_acc = r_enable && !empty_q && !clear;

  always_comb begin
    count_d = count_q;
    if (clear) count_d = '0;
    else       count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= AFullRst;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == DepthC);
      aempty_q <= (count_d <= AEmptyC);
      afull_q  <= (count_d >= AFullC);
      if (clear) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        ovf_q    <= 1'b0;
        unf_q    <= 1'b0;
      end else begin
        if (wr_acc) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (rd_acc) rd_ptr_q <= rd_ptr_q + PW'(1);
        if (w_enable && full_q)  ovf_q <= 1'b1;
        if (r_enable && empty_q) unf_q <= 1'b1;
      end
    end
  end

  fifo_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_regfile (
    .clk    (clk),
    .w_en   (wr_acc),
    .w_addr (wr_ptr_q),
    .w_data (w_data),
    .r_addr (rd_ptr_q),
    .r_data (rd_word)
  );

  if (FWFT) begin : g_fwft
    assign r_data = empty_q ? '0 : rd_word;
  end else begin : g_reg
    logic [WIDTH-1:0] r_data_q;
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)      r_data_q <= '0;
      else if (clear)  r_data_q <= '0;
      else if (rd_acc) r_data_q <= rd_word;
    end
    assign r_data = r_data_q;
  end

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = aempty_q;
  assign almost_full  = afull_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_gpu_param_fifo.sv
// Three FIFO configurations driven in lockstep and checked against a queue model.
module tb_gpu_param_fifo;

  logic       clk;
  logic       n_rst;
  logic       clear;
  logic       w_enable;
  logic [7:0] w_data;
  logic       r_enable;

  logic [7:0] rd_a, rd_b, rd_c;
  logic [3:0] cnt_a;
  logic [2:0] cnt_b, cnt_c;
  logic [2:0] empty_v, full_v, ae_v, af_v, ovf_v, unf_v;
  logic [7:0] rd_v  [3];
  logic [3:0] cnt_v [3];

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: one queue per configuration.
  logic [7:0] mq [3][$];
  logic [7:0] mr [3];
  bit         mo [3];
  bit         mu [3];
  int         dep [3];
  int         afth [3];
  int         aeth [3];
  bit         fw [3];

  gpu_param_fifo #(
    .WIDTH(8), .DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(1'b0)
  ) u_dut_a (
    .clk(clk), .n_rst(n_rst), .clear(clear), .w_enable(w_enable), .w_data(w_data),
    .r_enable(r_enable), .r_data(rd_a), .empty(empty_v[0]), .full(full_v[0]),
    .almost_empty(ae_v[0]), .almost_full(af_v[0]), .count(cnt_a),
    .overflow(ovf_v[0]), .underflow(unf_v[0])
  );

  gpu_param_fifo #(
    .WIDTH(8), .DEPTH(4), .FWFT(1'b1)
  ) u_dut_b (
    .clk(clk), .n_rst(n_rst), .clear(clear), .w_enable(w_enable), .w_data(w_data),
    .r_enable(r_enable), .r_data(rd_b), .empty(empty_v[1]), .full(full_v[1]),
    .almost_empty(ae_v[1]), .almost_full(af_v[1]), .count(cnt_b),
    .overflow(ovf_v[1]), .underflow(unf_v[1])
  );

  gpu_param_fifo #(
    .WIDTH(8), .DEPTH(4), .FWFT(1'b0)
  ) u_dut_c (
    .clk(clk), .n_rst(n_rst), .clear(clear), .w_enable(w_enable), .w_data(w_data),
    .r_enable(r_enable), .r_data(rd_c), .empty(empty_v[2]), .full(full_v[2]),
    .almost_empty(ae_v[2]), .almost_full(af_v[2]), .count(cnt_c),
    .overflow(ovf_v[2]), .underflow(unf_v[2])
  );

  assign rd_v[0]  = rd_a;
  assign rd_v[1]  = rd_b;
  assign rd_v[2]  = rd_c;
  assign cnt_v[0] = cnt_a;
  assign cnt_v[1] = {1'b0, cnt_b};
  assign cnt_v[2] = {1'b0, cnt_c};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      mr[i] = '0;
      mo[i] = 1'b0;
      mu[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit we, input logic [7:0] wd, input bit re, input bit clr);
    for (int i = 0; i < 3; i++) begin
      bit is_full, is_empty;
      is_full  = (mq[i].size() == dep[i]);
      is_empty = (mq[i].size() == 0);
      if (clr) begin
        mq[i].delete();
        mr[i] = '0;
        mo[i] = 1'b0;
        mu[i] = 1'b0;
      end else begin
        if (we && is_full)  mo[i] = 1'b1;
        if (re && is_empty) mu[i] = 1'b1;
        if (re && !is_empty) begin
          if (!fw[i]) mr[i] = mq[i][0];
          void'(mq[i].pop_front());
        end
        if (we && !is_full) mq[i].push_back(wd);
      end
    end
  endtask

  task automatic compare_all(input string ph);
    for (int i = 0; i < 3; i++) begin
      int n;
      logic [7:0] exp_rd;
      n = mq[i].size();
      if (fw[i]) exp_rd = (n > 0) ? mq[i][0] : 8'h00;
      else       exp_rd = mr[i];
      check($sformatf("%s d%0d count", ph, i), 32'(cnt_v[i]), 32'(n));
      check($sformatf("%s d%0d empty", ph, i), 32'(empty_v[i]), 32'(n == 0));
      check($sformatf("%s d%0d full", ph, i), 32'(full_v[i]), 32'(n == dep[i]));
      check($sformatf("%s d%0d almost_empty", ph, i), 32'(ae_v[i]), 32'(n <= aeth[i]));
      check($sformatf("%s d%0d almost_full", ph, i), 32'(af_v[i]), 32'(n >= afth[i]));
      check($sformatf("%s d%0d overflow", ph, i), 32'(ovf_v[i]), 32'(mo[i]));
      check($sformatf("%s d%0d underflow", ph, i), 32'(unf_v[i]), 32'(mu[i]));
      check($sformatf("%s d%0d r_data", ph, i), 32'(rd_v[i]), 32'(exp_rd));
    end
  endtask

  task automatic cycle(input string ph, input bit we, input logic [7:0] wd, input bit re,
                       input bit clr);
    @(negedge clk);
    w_enable = we;
    w_data   = wd;
    r_enable = re;
    clear    = clr;
    model_step(we, wd, re, clr);
    @(posedge clk);
    #1;
    compare_all(ph);
  endtask

  task automatic random_run(input string ph, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      int wp, rp;
      case ((c / 40) % 3)
        0:       begin wp = 85; rp = 25; end
        1:       begin wp = 25; rp = 85; end
        default: begin wp = 60; rp = 60; end
      endcase
      cycle(ph, ($urandom_range(99) < wp), 8'($urandom), ($urandom_range(99) < rp),
            ($urandom_range(99) < 3));
    end
  endtask

  initial begin
    dep  = '{8, 4, 4};
    afth = '{6, 3, 3};
    aeth = '{2, 1, 1};
    fw   = '{1'b0, 1'b1, 1'b0};
    n_rst    = 1'b0;
    clear    = 1'b0;
    w_enable = 1'b0;
    w_data   = '0;
    r_enable = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    n_rst = 1'b1;

    // Fill past DEPTH=4, then drain and read one past empty.
    for (int i = 1; i <= 5; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)  cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("flush", 1'b0, 8'h00, 1'b0, 1'b1);

    // Steady-state simultaneous read/write at count 2.
    cycle("pre", 1'b1, 8'h0a, 1'b0, 1'b0);
    cycle("pre", 1'b1, 8'h0b, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle("rw", 1'b1, 8'(8'h10 + i), 1'b1, 1'b0);

    // Clear together with a write drops the write.
    cycle("pre_clr", 1'b1, 8'h77, 1'b0, 1'b0);
    cycle("clr_w", 1'b1, 8'h99, 1'b0, 1'b1);

    // Fall-through visibility of a single word into an empty FIFO.
    cycle("fwft_w", 1'b1, 8'haa, 1'b0, 1'b0);
    cycle("fwft_idle", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("fwft_r", 1'b0, 8'h00, 1'b1, 1'b0);

    random_run("rand1", 360);

    // Asynchronous reset away from the clock edge.
    @(negedge clk);
    w_enable = 1'b1;
    r_enable = 1'b1;
    #2;
    n_rst = 1'b0;
    w_enable = 1'b0;
    r_enable = 1'b0;
    clear = 1'b0;
    model_reset();
    #1;
    compare_all("async_rst");
    #1;
    n_rst = 1'b1;

    random_run("rand2", 240);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
